// File: rtl/vga_sync_if.sv
// vga_sync_if: pixel-timing bundle between the sync generator and the graphics/DAC side
interface vga_sync_if;
  logic [11:0] rgb_in;
  logic        p_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        frame_tick;
  logic [11:0] rgb_out;
  modport master (input rgb_in, output p_tick, x, y, video_on, hsync, vsync, frame_tick, rgb_out);
  modport slave  (output rgb_in, input p_tick, x, y, video_on, hsync, vsync, frame_tick, rgb_out);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel divider, x/y raster counters, registered syncs and colour output
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input logic         clk,
  input logic         reset,
  vga_sync_if.master  v
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div, div_n;
  logic [9:0] x_n, y_n;
  logic tick_n, h_wrap, v_wrap;
  always_comb begin
    div_n  = div == DIV_LAST ? '0 : div + 1'b1;
    tick_n = div_n == DIV_LAST;
    h_wrap = v.x == H_LAST;
    v_wrap = v.y == V_LAST;
    x_n    = v.p_tick ? (h_wrap ? '0 : v.x + 10'd1) : v.x;
    y_n    = v.p_tick && h_wrap ? (v_wrap ? '0 : v.y + 10'd1) : v.y;
  end
  // syncs and video_on are computed from next counter values so they line up with x/y
  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      v.x          <= '0;
      v.y          <= '0;
      v.p_tick     <= 1'b0;
      v.frame_tick <= 1'b0;
      v.hsync      <= 1'b1;
      v.vsync      <= 1'b1;
      v.video_on   <= 1'b1;
      v.rgb_out    <= '0;
    end else begin
      div          <= div_n;
      v.x          <= x_n;
      v.y          <= y_n;
      v.p_tick     <= tick_n;
      v.frame_tick <= tick_n && x_n == H_LAST && y_n == V_LAST;
      v.hsync      <= !(x_n >= HS_BEG && x_n <= HS_END);
      v.vsync      <= !(y_n >= VS_BEG && y_n <= VS_END);
      v.video_on   <= x_n < H_VIS && y_n < V_VIS;
      if (v.p_tick) v.rgb_out <= v.video_on ? v.rgb_in : 12'h000;
    end
  end
endmodule
